seg7_decode_capture: RTL and testbench

//  Inverse of the hex-to-7-segment encoder. Watches a scanned, multiplexed 7-seg display bus
//  (shared active-low segment lines plus a one-hot digit select) and recovers each digit's hex

---
 rtl/seg7_decode_capture_if.sv | 23 ++
 rtl/seg7_decode_capture.sv | 148 ++++++++++++++
 tb/tb_seg7_decode_capture.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_decode_capture_if.sv
// Bus bundle for the 7-segment capture block: scanned display lines in, decoded frame out.
// The master side drives the display lines and out_ready; the slave side is the decoder.
interface seg7_decode_capture_if #(
    parameter int NUM_DIGITS = 6
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [4*NUM_DIGITS-1:0] out_data;
    logic [NUM_DIGITS-1:0]   out_err_mask;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_ovf;

    modport master (
        output seg_in, digit_sel, out_ready,
        input  out_data, out_err_mask, out_valid, out_ovf
    );

    modport slave (
        input  seg_in, digit_sel, out_ready,
        output out_data, out_err_mask, out_valid, out_ovf
    );
endinterface

// File: rtl/seg7_decode_capture.sv
// Recovers hex nibbles from a scanned, multiplexed active-low 7-segment bus and presents
// each complete frame (with per-digit decode errors) on a valid/ready output.
module seg7_decode_capture #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_decode_capture_if.slave bus,
    output logic                 fsm_state
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 7;

    localparam logic [0:0] ST_WAIT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [SW-1:0]           s_q;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [0:0]              state;
    logic [SW-1:0]           sample;
    logic                    lock_now;
    logic                    sel_onehot;
    logic                    commit;
    logic [2:0]              idx;
    logic [4:0]              dec;

    logic [4*NUM_DIGITS-1:0] frame_q;
    logic [4*NUM_DIGITS-1:0] frame_nxt;
    logic [NUM_DIGITS-1:0]   err_q;
    logic [NUM_DIGITS-1:0]   err_nxt;
    logic [NUM_DIGITS-1:0]   bitmap;
    logic [NUM_DIGITS-1:0]   bitmap_nxt;
    logic                    frame_done;
    logic                    slot_free;

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic                    valid_q;
    logic                    ovf_q;

    // Active-low segments, g is the MSB; blank or any unlisted pattern is an error.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b0000011: return 5'h0B;
            7'b0100111: return 5'h0C;
            7'b0100001: return 5'h0D;
            7'b0000110: return 5'h0E;
            7'b0001110: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    assign sample = {bus.digit_sel, bus.seg_in};

    always_comb begin
        if (sample != s_q) begin
            cnt_nxt = CW'(1);
        end else if (cnt == CW'(STABLE_CYCLES)) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Commit only on the WAIT->LOCKED step, so a long stable run commits exactly once.
    assign lock_now   = (cnt_nxt == CW'(STABLE_CYCLES));
    assign sel_onehot = (bus.digit_sel != '0) &&
                        ((bus.digit_sel & (bus.digit_sel - 1'b1)) == '0);
    assign commit     = (state == ST_WAIT) && lock_now && sel_onehot;
    assign dec        = seg_decode(bus.seg_in);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.digit_sel[i]) idx = 3'(i);
        end
    end

    always_comb begin
        frame_nxt  = frame_q;
        err_nxt    = err_q;
        bitmap_nxt = bitmap;
        if (commit) begin
            frame_nxt[4*idx +: 4] = dec[3:0];
            err_nxt[idx]          = dec[4];
            bitmap_nxt[idx]       = 1'b1;
        end
    end

    assign frame_done = &bitmap_nxt;
    assign slot_free  = !valid_q || bus.out_ready;

    // Handshake: a frame transfers on any edge with out_valid & out_ready; while out_valid is
    // high and out_ready low, out_data/out_err_mask hold. A new frame may load on the transfer edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            cnt     <= '0;
            state   <= ST_WAIT;
            frame_q <= '0;
            err_q   <= '0;
            bitmap  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s_q     <= sample;
            cnt     <= cnt_nxt;
            state   <= lock_now ? ST_LOCKED : ST_WAIT;
            frame_q <= frame_nxt;
            err_q   <= err_nxt;
            ovf_q   <= 1'b0;
            if (frame_done) begin
                bitmap <= '0;
                if (slot_free) begin
                    data_q  <= frame_nxt;
                    mask_q  <= err_nxt;
                    valid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else begin
                bitmap <= bitmap_nxt;
                if (valid_q && bus.out_ready) valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data     = data_q;
    assign bus.out_err_mask = mask_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_ovf      = ovf_q;
    assign fsm_state        = state[0];
endmodule

// File: tb/tb_seg7_decode_capture.sv
// Randomized and directed bench for seg7_decode_capture with a run-length reference model
// and an expected-frame queue popped by an independent output monitor.
module tb_seg7_decode_capture;
  localparam int ND = 6;
  localparam int SC = 4;
  localparam int W  = 5 * ND;

  logic clk = 1'b0;
  logic rst;
  logic fsm_state;

  seg7_decode_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_decode_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  int m_loads = 0;
  int n_xfer  = 0;

  // Reference model state: run length of the current sample, collected digits, output slot.
  logic [ND+6:0]   m_prev  = '0;
  int              m_run   = 0;
  logic [3:0]      m_nib  [ND];
  logic            m_err  [ND];
  bit              m_have [ND];
  bit              m_valid = 1'b0;
  bit              m_ovf   = 1'b0;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 16; k++) begin
      if (seg_tab[k] == p) return {1'b0, 4'(k)};
    end
    return 5'b10000;
  endfunction

  always @(posedge clk) begin
    logic [ND+6:0] cur;
    logic [4:0]    d;
    logic [W-1:0]  packed_frame;
    int            ones;
    int            pos;
    bit            full;
    if (rst) begin
      m_loads = m_loads - exp_q.size();
      exp_q.delete();
      m_prev  = '0;
      m_run   = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      for (int i = 0; i < ND; i++) m_have[i] = 1'b0;
    end else begin
      cur = {bus.digit_sel, bus.seg_in};
      if (m_run > 0 && cur == m_prev) m_run++;
      else m_run = 1;
      m_prev = cur;
      m_ovf  = 1'b0;
      ones = 0;
      pos  = 0;
      for (int i = 0; i < ND; i++) begin
        if (bus.digit_sel[i]) begin
          ones++;
          pos = i;
        end
      end
      if (m_run == SC && ones == 1) begin
        d = ref_decode(bus.seg_in);
        m_nib[pos]  = d[3:0];
        m_err[pos]  = d[4];
        m_have[pos] = 1'b1;
      end
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      full = 1'b1;
      for (int i = 0; i < ND; i++) if (!m_have[i]) full = 1'b0;
      if (full) begin
        if (!m_valid) begin
          for (int i = 0; i < ND; i++) begin
            packed_frame[4*i +: 4]  = m_nib[i];
            packed_frame[4*ND + i]  = m_err[i];
          end
          exp_q.push_back(packed_frame);
          m_loads++;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        for (int i = 0; i < ND; i++) m_have[i] = 1'b0;
      end
    end
  end

  // Monitor: looks just after each falling edge, once inputs for the next edge are settled.
  always @(negedge clk) begin
    logic [W-1:0] e;
    #1;
    checks++;
    if (bus.out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, bus.out_valid, m_valid);
    end
    checks++;
    if (bus.out_ovf !== m_ovf) begin
      errors++;
      $display("FAIL out_ovf @%0t: got %b expected %b", $time, bus.out_ovf, m_ovf);
    end
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      n_xfer++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame @%0t: unexpected frame data=%h mask=%b", $time,
                 bus.out_data, bus.out_err_mask);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_err_mask, bus.out_data} !== e) begin
          errors++;
          $display("FAIL frame @%0t: got data=%h mask=%b expected data=%h mask=%b", $time,
                   bus.out_data, bus.out_err_mask, e[4*ND-1:0], e[W-1:4*ND]);
        end
      end
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one sample for n cycles; called at a falling edge, returns at a falling edge.
  task automatic hold(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
    bus.digit_sel = sel;
    bus.seg_in    = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_frame(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                            input logic [3:0] v3, input logic [3:0] v4, input logic [3:0] v5);
    logic [3:0] v [ND];
    logic [ND-1:0] one;
    v = '{v0, v1, v2, v3, v4, v5};
    one = 1;
    for (int i = 0; i < ND; i++) hold(one << i, seg_tab[v[i]], 6);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.digit_sel = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [ND-1:0] one;
    logic [ND-1:0] sel;
    logic [6:0]    seg;
    one = 1;
    rst = 1'b1;
    bus.seg_in    = 7'h7F;
    bus.digit_sel = '0;
    bus.out_ready = 1'b0;

    // 1: reset with random inputs
    @(negedge clk);
    repeat (2) begin
      bus.seg_in    = 7'($urandom);
      bus.digit_sel = ND'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
    end
    settle();
    expect_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
    expect_eq("reset out_data", 32'(bus.out_data), 32'd0);
    expect_eq("reset out_err_mask", 32'(bus.out_err_mask), 32'd0);
    expect_eq("reset out_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // 2: basic frame 0x654321
    show_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
    settle();
    expect_eq("frame 654321 data", 32'(bus.out_data), 32'h654321);
    expect_eq("frame 654321 mask", 32'(bus.out_err_mask), 32'd0);
    @(negedge clk);

    // 3: digit 3 held only 3 cycles, then its proper 4-cycle hold completes the frame
    hold(one << 0, seg_tab[7], 6);
    hold(one << 1, seg_tab[8], 6);
    hold(one << 2, seg_tab[9], 6);
    hold(one << 3, seg_tab[10], 3);
    hold(one << 4, seg_tab[11], 6);
    hold(one << 5, seg_tab[12], 6);
    settle();
    expect_eq("short hold no frame", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    hold(one << 3, seg_tab[10], 4);
    settle();
    expect_eq("late digit3 valid", 32'(bus.out_valid), 32'd1);
    expect_eq("late digit3 data", 32'(bus.out_data), 32'hCBA987);
    @(negedge clk);
    bus.out_ready = 1'b1;
    hold('0, 7'h7F, 2);

    // 4: blank digit 2
    hold(one << 0, seg_tab[0], 6);
    hold(one << 1, seg_tab[1], 6);
    hold(one << 2, 7'b1111111, 6);
    hold(one << 3, seg_tab[3], 6);
    hold(one << 4, seg_tab[4], 6);
    hold(one << 5, seg_tab[5], 6);
    settle();
    expect_eq("blank digit data", 32'(bus.out_data), 32'h543010);
    expect_eq("blank digit mask", 32'(bus.out_err_mask), 32'h04);
    @(negedge clk);

    // 5: stalled output, second frame overflows
    bus.out_ready = 1'b0;
    show_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
    settle();
    expect_eq("stall frame A valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    show_frame(4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF);
    settle();
    expect_eq("ovf keeps data", 32'(bus.out_data), 32'h654321);
    @(negedge clk);
    bus.out_ready = 1'b1;
    hold('0, 7'h7F, 2);
    settle();
    expect_eq("after transfer valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);

    // 6: multi-hot select never commits; reset discards partial frame
    hold(6'b000011, seg_tab[1], 10);
    hold(one << 0, seg_tab[2], 6);
    hold(one << 1, seg_tab[2], 6);
    hold(one << 2, seg_tab[2], 6);
    do_reset(1);
    hold(one << 3, seg_tab[2], 6);
    hold(one << 4, seg_tab[2], 6);
    hold(one << 5, seg_tab[2], 6);
    settle();
    expect_eq("partial after reset", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    show_frame(4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2);
    settle();
    expect_eq("full frame after reset", 32'(bus.out_data), 32'h222222);
    @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 99) < 85) sel = one << $urandom_range(0, ND - 1);
      else sel = ND'($urandom);
      if ($urandom_range(0, 99) < 80) seg = seg_tab[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 199) == 0) do_reset(1);
      hold(sel, seg, $urandom_range(1, 7));
    end

    bus.out_ready = 1'b1;
    hold('0, 7'h7F, 10);
    settle();
    expect_eq("loads vs transfers", 32'(n_xfer), 32'(m_loads));
    expect_eq("queue drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
